alu_acc_seq: RTL and testbench

- Parametrised accumulator ALU: successor to the 8-bit combinational ALU, generalised to WIDTH bits.
- Holds the accumulator A and flags CY/Z in registers.
- Accepts one operation per valid/ready handshake against operand IN_R.
- Adds carry-chained ops, shifts, a zero flag and a multi-cycle shift-add multiply.
- Sits between the instruction decoder and the register file / datapath result bus.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_seq.sv | 84 ++++++++
 rtl/alu_acc_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_acc_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared opcode and FSM-state definitions for the accumulator ALU.
//   ALU_OP_W     : opcode width
//   alu_op_e     : opcode encodings (0000-0110 match the older 8-bit ALU)
//   alu_state_e  : sequencer states of alu_acc_seq
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_OR  = 4'b0010,
    ALU_AND = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_NOT = 4'b0101,
    ALU_LD  = 4'b0110,
    ALU_ADC = 4'b0111,
    ALU_SBC = 4'b1000,
    ALU_SHL = 4'b1001,
    ALU_SHR = 4'b1010,
    ALU_MUL = 4'b1011,
    ALU_CLR = 4'b1100
  } alu_op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

endpackage : alu_pkg

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
// Sequential shift-add multiplier, one partial-product step per clock.
// A start pulse latches the operands; WIDTH steps later the product is ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : latch mcand/mplier and begin (ignored while busy)
//   mcand      : multiplicand
//   mplier     : multiplier
//   busy       : a multiplication is in progress
//   done       : high during the cycle whose closing edge performs the final
//                step; result/overflow show the finished product then, so the
//                consumer can register it on that same edge
//   result     : low WIDTH bits of the finished product
//   overflow   : OR of the high WIDTH bits of the finished product
// ---------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  logic             busy_r;
  logic [CNT_W-1:0] step_cnt_r;
  logic [PW-1:0]    mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [PW-1:0]    prod_r;
  logic [PW-1:0]    addend_s;
  logic [PW-1:0]    prod_nxt_s;
  logic             last_step_s;

  // Partial-product add for the current step and detection of the final step.
  always_comb begin
    addend_s    = mplier_r[0] ? mcand_r : {PW{1'b0}};
    prod_nxt_s  = prod_r + addend_s;
    last_step_s = busy_r && (step_cnt_r == CNT_W'(WIDTH - 1));
  end

  // Operand shift registers, running product and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      step_cnt_r <= {CNT_W{1'b0}};
      mcand_r    <= {PW{1'b0}};
      mplier_r   <= {WIDTH{1'b0}};
      prod_r     <= {PW{1'b0}};
    end else if (busy_r) begin
      prod_r   <= prod_nxt_s;
      // Multiplicand moves up one weight, multiplier exposes its next bit.
      mcand_r  <= {mcand_r[PW-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      if (last_step_s) begin
        busy_r     <= 1'b0;
        step_cnt_r <= {CNT_W{1'b0}};
      end else begin
        step_cnt_r <= step_cnt_r + CNT_W'(1);
      end
    end else if (start) begin
      busy_r     <= 1'b1;
      step_cnt_r <= {CNT_W{1'b0}};
      mcand_r    <= {{WIDTH{1'b0}}, mcand};
      mplier_r   <= mplier;
      prod_r     <= {PW{1'b0}};
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign busy     = busy_r;
  assign done     = last_step_s;
  assign result   = prod_nxt_s[WIDTH-1:0];
  assign overflow = |prod_nxt_s[PW-1:WIDTH];

endmodule : alu_mul_seq

// File: rtl/alu_acc_seq.sv
// ---------------------------------------------------------------------------
// alu_acc_seq
// Accumulator ALU: holds A, CY and Z in registers and applies one operation
// per IN_VALID/OUT_READY handshake using operand IN_R.
// Build option: define ALU_ACC_MUL_EN to include the multi-cycle multiplier;
// without it opcode 1011 is a single-cycle no-op and OUT_READY stays 1.
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   IN_VALID   : operation request, taken when IN_VALID && OUT_READY
//   IN_OP      : opcode (alu_pkg::alu_op_e)
//   IN_R       : operand
//   OUT_READY  : idle, an operation can be accepted
//   OUT_DONE   : one-cycle pulse after A/CY/Z were updated by an operation
//   OUT_A      : accumulator
//   OUT_CY     : carry / borrow / shifted-out / overflow flag
//   OUT_Z      : A == 0 after the last completed operation
// ---------------------------------------------------------------------------
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IN_VALID,
  input  logic [ALU_OP_W-1:0] IN_OP,
  input  logic [WIDTH-1:0]    IN_R,
  output logic                OUT_READY,
  output logic                OUT_DONE,
  output logic [WIDTH-1:0]    OUT_A,
  output logic                OUT_CY,
  output logic                OUT_Z
);

  logic [WIDTH-1:0] acc_r;
  logic             cy_r;
  logic             z_r;
  logic             done_r;
  logic             ready_r;

  logic [WIDTH-1:0] acc_nxt_s;
  logic             cy_nxt_s;
  logic             z_nxt_s;
  logic             done_nxt_s;
  logic             ready_nxt_s;
  logic             accept_s;
  alu_op_e          op_s;
  logic [WIDTH+1:0] exec_s;

  // Single-cycle datapath. Returns {update, cy, a}; the carry lives in bit
  // WIDTH of a WIDTH+1 bit result so add/sub carry and borrow fall out
  // naturally. update=0 marks a no-op (A/CY/Z must be left alone).
  function automatic logic [WIDTH+1:0] exec_op(
    input alu_op_e          op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] r,
    input logic             cy
  );
    logic [WIDTH:0] ea;
    logic [WIDTH:0] er;
    logic [WIDTH:0] ec;
    logic [WIDTH:0] res;
    logic           upd;
    ea  = {1'b0, a};
    er  = {1'b0, r};
    ec  = {{WIDTH{1'b0}}, cy};
    res = {(WIDTH + 1){1'b0}};
    upd = 1'b1;
    case (op)
      ALU_ADD: res = ea + er;
      ALU_SUB: res = ea - er;
      ALU_OR:  res = {1'b0, a | r};
      ALU_AND: res = {1'b0, a & r};
      ALU_XOR: res = {1'b0, a ^ r};
      ALU_NOT: res = {1'b0, ~a};
      ALU_LD:  res = er;
      ALU_ADC: res = ea + er + ec;
      ALU_SBC: res = ea - er - ec;
      ALU_SHL: res = {a, 1'b0};
      ALU_SHR: res = {a[0], 1'b0, a[WIDTH-1:1]};
      ALU_CLR: res = {(WIDTH + 1){1'b0}};
      default: begin
        res = {cy, a};
        upd = 1'b0;
      end
    endcase
    return {upd, res};
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  assign op_s   = alu_op_e'(IN_OP);
  assign exec_s = exec_op(op_s, acc_r, IN_R, cy_r);

`ifdef ALU_ACC_MUL_EN

  alu_state_e       state_r;
  alu_state_e       state_nxt_s;
  logic             mul_start_s;
  logic             mul_busy_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_result_s;
  logic             mul_ovf_s;

  // The multiplier's own busy flag also gates acceptance so a request can
  // never slip in while a product is still being formed.
  assign accept_s = IN_VALID && ready_r && !mul_busy_s;

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start    (mul_start_s),
    .mcand    (acc_r),
    .mplier   (IN_R),
    .busy     (mul_busy_s),
    .done     (mul_done_s),
    .result   (mul_result_s),
    .overflow (mul_ovf_s)
  );

  // Sequencer state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, handshake and accumulator/flag update decode.
  always_comb begin
    acc_nxt_s   = acc_r;
    cy_nxt_s    = cy_r;
    z_nxt_s     = z_r;
    done_nxt_s  = 1'b0;
    ready_nxt_s = ready_r;
    state_nxt_s = state_r;
    mul_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && (op_s == ALU_MUL)) begin
          // Flags stay frozen until the product is complete.
          mul_start_s = 1'b1;
          ready_nxt_s = 1'b0;
          state_nxt_s = MUL;
        end else if (accept_s) begin
          done_nxt_s = 1'b1;
          if (exec_s[WIDTH+1]) begin
            acc_nxt_s = exec_s[WIDTH-1:0];
            cy_nxt_s  = exec_s[WIDTH];
            z_nxt_s   = is_zero(exec_s[WIDTH-1:0]);
          end else begin
            acc_nxt_s = acc_r;
          end
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          acc_nxt_s   = mul_result_s;
          cy_nxt_s    = mul_ovf_s;
          z_nxt_s     = is_zero(mul_result_s);
          done_nxt_s  = 1'b1;
          ready_nxt_s = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          ready_nxt_s = 1'b0;
        end
      end
      default: begin
        ready_nxt_s = 1'b1;
        state_nxt_s = IDLE;
      end
    endcase
  end

`else

  assign accept_s = IN_VALID && ready_r;

  // Accumulator/flag update decode; every operation completes in one cycle.
  always_comb begin
    acc_nxt_s   = acc_r;
    cy_nxt_s    = cy_r;
    z_nxt_s     = z_r;
    done_nxt_s  = 1'b0;
    ready_nxt_s = 1'b1;
    if (accept_s) begin
      done_nxt_s = 1'b1;
      if (exec_s[WIDTH+1]) begin
        acc_nxt_s = exec_s[WIDTH-1:0];
        cy_nxt_s  = exec_s[WIDTH];
        z_nxt_s   = is_zero(exec_s[WIDTH-1:0]);
      end else begin
        acc_nxt_s = acc_r;
      end
    end else begin
      done_nxt_s = 1'b0;
    end
  end

`endif

  // Architectural registers: accumulator, flags, done pulse and ready.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_r   <= {WIDTH{1'b0}};
      cy_r    <= 1'b0;
      z_r     <= 1'b1;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      acc_r   <= acc_nxt_s;
      cy_r    <= cy_nxt_s;
      z_r     <= z_nxt_s;
      done_r  <= done_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  assign OUT_A     = acc_r;
  assign OUT_CY    = cy_r;
  assign OUT_Z     = z_r;
  assign OUT_DONE  = done_r;
  assign OUT_READY = ready_r;

endmodule : alu_acc_seq

// File: tb/tb_alu_acc_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_acc_seq
// Self-checking bench for alu_acc_seq (WIDTH=8). Expected A/CY/Z triples are
// queued when an operation is driven and compared whenever OUT_DONE is seen.
// Works with or without ALU_ACC_MUL_EN defined.
// ---------------------------------------------------------------------------
module tb_alu_acc_seq;
  import alu_pkg::*;

  localparam int WIDTH = 8;
`ifdef ALU_ACC_MUL_EN
  localparam int MUL_CYC = 8;
`else
  localparam int MUL_CYC = 0;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic       cy;
    logic       z;
  } exp_t;

  logic                CLK;
  logic                RST_N;
  logic                IN_VALID;
  logic [ALU_OP_W-1:0] IN_OP;
  logic [WIDTH-1:0]    IN_R;
  logic                OUT_READY;
  logic                OUT_DONE;
  logic [WIDTH-1:0]    OUT_A;
  logic                OUT_CY;
  logic                OUT_Z;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  alu_acc_seq #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_OP     (IN_OP),
    .IN_R      (IN_R),
    .OUT_READY (OUT_READY),
    .OUT_DONE  (OUT_DONE),
    .OUT_A     (OUT_A),
    .OUT_CY    (OUT_CY),
    .OUT_Z     (OUT_Z)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard: each DONE pulse retires the oldest expected result.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && OUT_DONE === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: A=%02h CY=%0b Z=%0b with nothing outstanding", OUT_A, OUT_CY, OUT_Z);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({OUT_A, OUT_CY, OUT_Z} !== {e.a, e.cy, e.z}) begin
          errors++;
          $display("FAIL result: got A=%02h CY=%0b Z=%0b, want A=%02h CY=%0b Z=%0b",
                   OUT_A, OUT_CY, OUT_Z, e.a, e.cy, e.z);
        end
      end
    end
  end

  // Drive one request at a falling edge, optionally queue its outcome, and
  // return at the next falling edge (the cycle in which DONE is visible).
  task automatic send(input logic [3:0] op, input logic [7:0] r, input bit push,
                      input logic [7:0] ea, input logic ecy, input logic ez);
    exp_t e;
    IN_VALID = 1'b1;
    IN_OP    = op;
    IN_R     = r;
    if (push) begin
      e.a = ea; e.cy = ecy; e.z = ez;
      sb_q.push_back(e);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #2 RST_N = 1'b0;
    #1;
    checks += 5;
    if (OUT_A !== 8'h00)    begin errors++; $display("FAIL reset_a: got %02h want 00", OUT_A); end
    if (OUT_CY !== 1'b0)    begin errors++; $display("FAIL reset_cy: got %0b want 0", OUT_CY); end
    if (OUT_Z !== 1'b1)     begin errors++; $display("FAIL reset_z: got %0b want 1", OUT_Z); end
    if (OUT_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", OUT_READY); end
    if (OUT_DONE !== 1'b0)  begin errors++; $display("FAIL reset_done: got %0b want 0", OUT_DONE); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_add_chain();
    int dones;
    dones = 0;
    send(ALU_LD,  8'hF0, 1'b1, 8'hF0, 1'b0, 1'b0);
    if (OUT_DONE === 1'b1) dones++;
    send(ALU_ADD, 8'h20, 1'b1, 8'h10, 1'b1, 1'b0);
    if (OUT_DONE === 1'b1) dones++;
    send(ALU_ADC, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0);
    if (OUT_DONE === 1'b1) dones++;
    IN_VALID = 1'b0;
    @(negedge CLK);
    checks += 2;
    if (dones != 3) begin errors++; $display("FAIL b2b_done_run: got %0d want 3", dones); end
    if (OUT_DONE !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %0b want 0", OUT_DONE); end
  endtask

  task automatic test_sub_chain();
    send(ALU_LD,  8'h05, 1'b1, 8'h05, 1'b0, 1'b0);
    send(ALU_SUB, 8'h06, 1'b1, 8'hFF, 1'b1, 1'b0);
    send(ALU_SBC, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);
    IN_VALID = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_shift();
    send(ALU_LD,  8'h81, 1'b1, 8'h81, 1'b0, 1'b0);
    send(ALU_SHL, 8'hAA, 1'b1, 8'h02, 1'b1, 1'b0);
    send(ALU_SHR, 8'h55, 1'b1, 8'h01, 1'b0, 1'b0);
    send(ALU_CLR, 8'h77, 1'b1, 8'h00, 1'b0, 1'b1);
    IN_VALID = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_logic_noop();
    send(ALU_LD,  8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0);
    send(ALU_OR,  8'hC3, 1'b1, 8'hFF, 1'b0, 1'b0);
    send(ALU_AND, 8'h0F, 1'b1, 8'h0F, 1'b0, 1'b0);
    send(ALU_XOR, 8'hFF, 1'b1, 8'hF0, 1'b0, 1'b0);
    send(ALU_NOT, 8'h00, 1'b1, 8'h0F, 1'b0, 1'b0);
    send(ALU_ADD, 8'hF1, 1'b1, 8'h00, 1'b1, 1'b1);
    // Reserved opcodes: DONE pulses, A/CY/Z untouched (CY=1 must survive).
    send(4'b1101, 8'h12, 1'b1, 8'h00, 1'b1, 1'b1);
    send(4'b1111, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1);
    IN_VALID = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_mul(input logic [7:0] ld_val, input logic [7:0] mul_r,
                          input logic [7:0] pa, input logic pcy, input logic pz);
    int busy_cyc;
    int dones;
    int held_bad;
    logic [7:0] fa;
    logic       fcy;
    logic       fz;
    send(ALU_LD, ld_val, 1'b1, ld_val, 1'b0, 1'b0);
`ifdef ALU_ACC_MUL_EN
    fa = pa; fcy = pcy; fz = pz;
    send(ALU_MUL, mul_r, 1'b1, fa, fcy, fz);
    // A competing request held high while busy must be dropped.
    IN_OP = ALU_LD;
    IN_R  = 8'h55;
`else
    fa = ld_val; fcy = 1'b0; fz = 1'b0;
    send(ALU_MUL, mul_r, 1'b1, fa, fcy, fz);
    IN_VALID = 1'b0;
`endif
    busy_cyc = 0; dones = 0; held_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (OUT_DONE === 1'b1) dones++;
      if (OUT_READY === 1'b1) break;
      busy_cyc++;
      if (OUT_A !== ld_val || OUT_CY !== 1'b0 || OUT_DONE !== 1'b0) held_bad++;
      IN_R = IN_R + 8'h01;
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    @(negedge CLK);
    checks += 5;
    if (busy_cyc != MUL_CYC) begin errors++; $display("FAIL mul_busy_cycles: got %0d want %0d", busy_cyc, MUL_CYC); end
    if (dones != 1) begin errors++; $display("FAIL mul_done_count: got %0d want 1", dones); end
    if (held_bad != 0) begin errors++; $display("FAIL mul_hold: %0d busy cycles disturbed A/CY/DONE, want 0", held_bad); end
    if (OUT_DONE !== 1'b0) begin errors++; $display("FAIL mul_done_after: got %0b want 0", OUT_DONE); end
    if ({OUT_A, OUT_CY, OUT_Z} !== {fa, fcy, fz}) begin
      errors++;
      $display("FAIL mul_final: got A=%02h CY=%0b Z=%0b want A=%02h CY=%0b Z=%0b", OUT_A, OUT_CY, OUT_Z, fa, fcy, fz);
    end
  endtask

  task automatic test_mul_reset();
    logic exp_rdy;
    exp_rdy = (MUL_CYC != 0) ? 1'b0 : 1'b1;
    send(ALU_LD, 8'h07, 1'b1, 8'h07, 1'b0, 1'b0);
`ifdef ALU_ACC_MUL_EN
    send(ALU_MUL, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0);
`else
    send(ALU_MUL, 8'h03, 1'b1, 8'h07, 1'b0, 1'b0);
`endif
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (OUT_READY !== exp_rdy) begin errors++; $display("FAIL abort_busy_ready: got %0b want %0b", OUT_READY, exp_rdy); end
    #2 RST_N = 1'b0;
    #1;
    checks += 5;
    if (OUT_A !== 8'h00)    begin errors++; $display("FAIL abort_a: got %02h want 00", OUT_A); end
    if (OUT_CY !== 1'b0)    begin errors++; $display("FAIL abort_cy: got %0b want 0", OUT_CY); end
    if (OUT_Z !== 1'b1)     begin errors++; $display("FAIL abort_z: got %0b want 1", OUT_Z); end
    if (OUT_READY !== 1'b1) begin errors++; $display("FAIL abort_ready: got %0b want 1", OUT_READY); end
    if (OUT_DONE !== 1'b0)  begin errors++; $display("FAIL abort_done: got %0b want 0", OUT_DONE); end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    send(ALU_LD, 8'h3A, 1'b1, 8'h3A, 1'b0, 1'b0);
    IN_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (OUT_A !== 8'h3A) begin errors++; $display("FAIL abort_next_ld: got %02h want 3a", OUT_A); end
  endtask

  initial begin
    RST_N    = 1'b1;
    IN_VALID = 1'b0;
    IN_OP    = 4'b0000;
    IN_R     = 8'h00;
    test_reset();
    test_add_chain();
    test_sub_chain();
    test_shift();
    test_logic_noop();
    test_mul(8'h10, 8'h20, 8'h00, 1'b1, 1'b1);
    test_mul(8'h0F, 8'h03, 8'h2D, 1'b0, 1'b0);
    test_mul_reset();
    repeat (2) @(negedge CLK);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL outstanding: %0d results never completed, want 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu_acc_seq
